// File: rtl/beagleg_pkg.sv
// rtl/beagleg_pkg.sv - shared types and timing defaults for the step pulse shaper
package beagleg_pkg;

    typedef enum logic [1:0] {
        SHAPER_IDLE,
        SHAPER_SETUP,
        SHAPER_HIGH,
        SHAPER_LOW
    } step_shaper_state_e;

    localparam int STEP_SYNC_STAGES_DEFAULT = 2;
    localparam int STEP_PULSE_WIDTH_DEFAULT = 8;
    localparam int STEP_MIN_LOW_DEFAULT     = 8;
    localparam int STEP_DIR_SETUP_DEFAULT   = 4;
    localparam int STEP_DIR_HOLD_DEFAULT    = 4;
    localparam int STEP_QUEUE_AW_DEFAULT    = 4;

    // Largest of three timing values; sizes the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/step_dir_queue.sv
// rtl/step_dir_queue.sv - 1-bit wide synchronous FIFO holding queued step directions
module step_dir_queue #(
    parameter int QUEUE_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              din,
    output logic              dout,
    output logic              full,
    output logic              empty,
    output logic [QUEUE_AW:0] count
);

    localparam int                  DEPTH   = 2 ** QUEUE_AW;
    localparam logic [QUEUE_AW:0]   CNT_ONE = (QUEUE_AW + 1)'(1);
    localparam logic [QUEUE_AW:0]   CNT_MAX = (QUEUE_AW + 1)'(DEPTH);
    localparam logic [QUEUE_AW-1:0] PTR_ONE = QUEUE_AW'(1);

    logic [DEPTH-1:0]    r_mem;
    logic [QUEUE_AW-1:0] r_wr_ptr;
    logic [QUEUE_AW-1:0] r_rd_ptr;
    logic [QUEUE_AW:0]   r_count;
    logic                w_do_pop;
    logic                w_do_push;

    // A push into a full queue is still taken when a pop frees a slot in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_MAX);
    assign empty = (r_count == '0);
    assign count = r_count;

    // Pointer, occupancy and storage update; flush discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/step_pulse_shaper.sv
// rtl/step_pulse_shaper.sv - shapes raw step edges into driver-legal STEP/DIR timing
module step_pulse_shaper
    import beagleg_pkg::*;
#(
    parameter int SYNC_STAGES = STEP_SYNC_STAGES_DEFAULT,
    parameter int PULSE_WIDTH = STEP_PULSE_WIDTH_DEFAULT,
    parameter int MIN_LOW     = STEP_MIN_LOW_DEFAULT,
    parameter int DIR_SETUP   = STEP_DIR_SETUP_DEFAULT,
    parameter int DIR_HOLD    = STEP_DIR_HOLD_DEFAULT,
    parameter int QUEUE_AW    = STEP_QUEUE_AW_DEFAULT,
    parameter bit INVERT_STEP = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              step_in,
    input  logic              dir_in,
    output logic              step_pulse,
    output logic              dir_out,
    output logic              busy,
    output logic [QUEUE_AW:0] pending_count,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam int             CNT_W      = $clog2(max3(PULSE_WIDTH, MIN_LOW, DIR_SETUP) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] LOAD_HIGH  = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] LOAD_LOW   = CNT_W'(MIN_LOW - 1);
    localparam logic             STEP_IDLE  = INVERT_STEP;
    localparam logic             STEP_ACT   = ~INVERT_STEP;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("step_pulse_shaper: SYNC_STAGES must be at least 2");
    end
    if (PULSE_WIDTH < 1 || MIN_LOW < 1 || DIR_SETUP < 1) begin : g_bad_timing
        $error("step_pulse_shaper: PULSE_WIDTH, MIN_LOW and DIR_SETUP must be at least 1");
    end
    if (MIN_LOW < DIR_HOLD) begin : g_bad_hold
        $error("step_pulse_shaper: MIN_LOW must cover DIR_HOLD");
    end

    logic [SYNC_STAGES-1:0] r_step_sync;
    logic [SYNC_STAGES-1:0] r_dir_sync;
    logic                   r_step_prev;
    step_shaper_state_e     r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_step_pulse;
    logic                   r_dir_out;
    logic                   r_overflow;

    logic w_step_s;
    logic w_dir_s;
    logic w_edge;
    logic w_push;
    logic w_pop;
    logic w_q_dir;
    logic w_full;
    logic w_empty;
    logic w_drop;

    assign w_step_s = r_step_sync[SYNC_STAGES-1];
    assign w_dir_s  = r_dir_sync[SYNC_STAGES-1];
    assign w_edge   = w_step_s & ~r_step_prev;
    assign w_push   = w_edge & enable;
    // Starting new pulses is suppressed while disabled so a flush never races a pop.
    assign w_pop    = (r_state == SHAPER_IDLE) & ~w_empty & enable;
    assign w_drop   = w_push & w_full & ~w_pop;

    // Synchronize step and direction through matching chains so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_sync <= '0;
            r_dir_sync  <= '0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step_in};
            r_dir_sync  <= {r_dir_sync[SYNC_STAGES-2:0], dir_in};
            r_step_prev <= w_step_s;
        end
    end

    step_dir_queue #(
        .QUEUE_AW (QUEUE_AW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (~enable),
        .din   (w_dir_s),
        .dout  (w_q_dir),
        .full  (w_full),
        .empty (w_empty),
        .count (pending_count)
    );

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Pulse timing FSM: DIR only moves when leaving IDLE, so hold is covered by LOW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SHAPER_IDLE;
            r_cnt        <= '0;
            r_step_pulse <= STEP_IDLE;
            r_dir_out    <= 1'b0;
        end else begin
            case (r_state)
                SHAPER_IDLE: begin
                    if (w_pop) begin
                        if (w_q_dir != r_dir_out) begin
                            r_dir_out <= w_q_dir;
                            r_cnt     <= LOAD_SETUP;
                            r_state   <= SHAPER_SETUP;
                        end else begin
                            r_cnt        <= LOAD_HIGH;
                            r_step_pulse <= STEP_ACT;
                            r_state      <= SHAPER_HIGH;
                        end
                    end
                end
                SHAPER_SETUP: begin
                    if (r_cnt == '0) begin
                        r_cnt        <= LOAD_HIGH;
                        r_step_pulse <= STEP_ACT;
                        r_state      <= SHAPER_HIGH;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                SHAPER_HIGH: begin
                    if (r_cnt == '0) begin
                        r_cnt        <= LOAD_LOW;
                        r_step_pulse <= STEP_IDLE;
                        r_state      <= SHAPER_LOW;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                SHAPER_LOW: begin
                    if (r_cnt == '0) begin
                        r_state <= SHAPER_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state      <= SHAPER_IDLE;
                    r_step_pulse <= STEP_IDLE;
                end
            endcase
        end
    end

    assign step_pulse = r_step_pulse;
    assign dir_out    = r_dir_out;
    assign overflow   = r_overflow;
    assign busy       = (r_state != SHAPER_IDLE) || !w_empty;

endmodule

// File: tb/tb_step_pulse_shaper.sv
// tb/tb_step_pulse_shaper.sv - directed self-checking bench for step_pulse_shaper
module tb_step_pulse_shaper;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       step_in;
    logic       dir_in;
    logic       clear_overflow;
    logic       step_pulse;
    logic       dir_out;
    logic       busy;
    logic [4:0] pending_count;
    logic       overflow;
    logic       inv_step_pulse;
    logic       inv_dir_out;
    logic       inv_busy;
    logic [4:0] inv_pending_count;
    logic       inv_overflow;

    int vec    = 0;
    int miscmp = 0;
    int cyc    = 0;
    int rise_q[$];
    logic prev_sp = 1'b0;

    step_pulse_shaper u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .step_in        (step_in),
        .dir_in         (dir_in),
        .step_pulse     (step_pulse),
        .dir_out        (dir_out),
        .busy           (busy),
        .pending_count  (pending_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    step_pulse_shaper #(.INVERT_STEP(1'b1)) u_inv (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .step_in        (step_in),
        .dir_in         (dir_in),
        .step_pulse     (inv_step_pulse),
        .dir_out        (inv_dir_out),
        .busy           (inv_busy),
        .pending_count  (inv_pending_count),
        .overflow       (inv_overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_pulse === 1'b1 && prev_sp === 1'b0) rise_q.push_back(cyc);
        prev_sp = step_pulse;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; step_in = 1'b0; dir_in = 1'b0; clear_overflow = 1'b0;
        #23;
        vec++;
        if ({step_pulse, dir_out, busy, pending_count, overflow} !== 9'b0) begin
            miscmp++;
            $display("FAIL reset_main got %b exp %b", {step_pulse, dir_out, busy, pending_count, overflow}, 9'b0);
        end
        vec++;
        if ({inv_step_pulse, inv_dir_out, inv_busy, inv_pending_count, inv_overflow} !== 9'b1_0000_0000) begin
            miscmp++;
            $display("FAIL reset_inv got %b exp %b", {inv_step_pulse, inv_dir_out, inv_busy, inv_pending_count, inv_overflow}, 9'b1_0000_0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vec++;
        if ({step_pulse, dir_out, busy, pending_count} !== 8'b0) begin
            miscmp++;
            $display("FAIL reset_idle got %b exp %b", {step_pulse, dir_out, busy, pending_count}, 8'b0);
        end
    endtask

    task automatic test_single_step();
        logic [7:0] exp;
        dir_in = 1'b0; step_in = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            tick();
            step_in = 1'b0;
            exp = {(n >= 4 && n <= 11), 1'b0, (n >= 3 && n <= 19), ((n == 3) ? 5'd1 : 5'd0)};
            vec++;
            if ({step_pulse, dir_out, busy, pending_count} !== exp) begin
                miscmp++;
                $display("FAIL single n=%0d got %b exp %b", n, {step_pulse, dir_out, busy, pending_count}, exp);
            end
        end
    endtask

    task automatic test_dir_change();
        logic [6:0] exp;
        logic       e_dir;
        logic [4:0] e_pend;
        dir_in = 1'b1; step_in = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            step_in = (n == 2);
            if (n == 2) dir_in = 1'b0;
            e_dir  = (n >= 4 && n <= 24);
            e_pend = (n == 3 || (n >= 5 && n <= 24)) ? 5'd1 : 5'd0;
            exp = {((n >= 8 && n <= 15) || n >= 29), e_dir, e_pend};
            vec++;
            if ({step_pulse, dir_out, pending_count} !== exp) begin
                miscmp++;
                $display("FAIL dir n=%0d got %b exp %b", n, {step_pulse, dir_out, pending_count}, exp);
            end
        end
        for (int i = 0; i < 100 && busy; i++) tick();
        vec++;
        if (busy !== 1'b0 || dir_out !== 1'b0) begin
            miscmp++;
            $display("FAIL dir_drain got busy=%b dir=%b exp busy=0 dir=0", busy, dir_out);
        end
    endtask

    task automatic test_burst_overflow();
        int r0, dmin, dmax, d;
        r0 = rise_q.size();
        dir_in = 1'b0; step_in = 1'b1;
        for (int n = 1; n <= 41; n++) begin
            tick();
            step_in = (n % 2 == 0) && (n / 2 <= 19);
            if (n == 37) begin
                vec++;
                if (pending_count !== 5'd16) begin
                    miscmp++; $display("FAIL burst_full got %0d exp 16", pending_count);
                end
            end
            if (n == 40) begin
                vec++;
                if (overflow !== 1'b0) begin
                    miscmp++; $display("FAIL burst_early_ovf got %b exp 0", overflow);
                end
            end
            if (n == 41) begin
                vec++;
                if ({overflow, pending_count} !== {1'b1, 5'd16}) begin
                    miscmp++; $display("FAIL burst_drop got ovf=%b cnt=%0d exp ovf=1 cnt=16", overflow, pending_count);
                end
            end
        end
        for (int i = 0; i < 600 && busy; i++) tick();
        vec++;
        if (busy !== 1'b0 || rise_q.size() - r0 != 19) begin
            miscmp++; $display("FAIL burst_pulses got busy=%b pulses=%0d exp busy=0 pulses=19", busy, rise_q.size() - r0);
        end
        dmin = 1000; dmax = 0;
        for (int i = r0 + 1; i < rise_q.size(); i++) begin
            d = rise_q[i] - rise_q[i-1];
            if (d < dmin) dmin = d;
            if (d > dmax) dmax = d;
        end
        vec++;
        if (dmin != 17 || dmax != 17) begin
            miscmp++; $display("FAIL burst_spacing got min=%0d max=%0d exp 17", dmin, dmax);
        end
        vec++;
        if (overflow !== 1'b1) begin
            miscmp++; $display("FAIL burst_sticky got %b exp 1", overflow);
        end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        vec++;
        if (overflow !== 1'b0) begin
            miscmp++; $display("FAIL burst_clear got %b exp 0", overflow);
        end
    endtask

    task automatic test_full_with_pop();
        int r0;
        r0 = rise_q.size();
        dir_in = 1'b0; step_in = 1'b1;
        for (int n = 1; n <= 56; n++) begin
            tick();
            step_in = (n % 2 == 0) && ((n / 2 <= 18) || (n / 2 == 26));
            if (n == 38) begin
                vec++;
                if (pending_count !== 5'd15) begin
                    miscmp++; $display("FAIL fullpop_pop got %0d exp 15", pending_count);
                end
            end
            if (n == 54 || n == 55) begin
                vec++;
                if ({overflow, pending_count} !== {1'b0, 5'd16}) begin
                    miscmp++; $display("FAIL fullpop n=%0d got ovf=%b cnt=%0d exp ovf=0 cnt=16", n, overflow, pending_count);
                end
            end
        end
        for (int i = 0; i < 600 && busy; i++) tick();
        vec++;
        if (busy !== 1'b0 || overflow !== 1'b0 || rise_q.size() - r0 != 20) begin
            miscmp++; $display("FAIL fullpop_drain got busy=%b ovf=%b pulses=%0d exp 0 0 20", busy, overflow, rise_q.size() - r0);
        end
    endtask

    task automatic test_enable_flush();
        int r0;
        r0 = rise_q.size();
        dir_in = 1'b0; step_in = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            step_in = (n % 2 == 0) && (n / 2 <= 6);
            if (n == 23) begin
                vec++;
                if (pending_count !== 5'd5 || step_pulse !== 1'b1) begin
                    miscmp++; $display("FAIL flush_pre got cnt=%0d sp=%b exp cnt=5 sp=1", pending_count, step_pulse);
                end
                enable = 1'b0;
            end
            if (n == 24) begin
                vec++;
                if (pending_count !== 5'd0) begin
                    miscmp++; $display("FAIL flush_cnt got %0d exp 0", pending_count);
                end
            end
            if (n >= 24 && n <= 29) begin
                vec++;
                if (step_pulse !== (n <= 28)) begin
                    miscmp++; $display("FAIL flush_pulse n=%0d got %b exp %b", n, step_pulse, (n <= 28));
                end
            end
            if (n == 36 || n == 37) begin
                vec++;
                if (busy !== (n == 36)) begin
                    miscmp++; $display("FAIL flush_busy n=%0d got %b exp %b", n, busy, (n == 36));
                end
            end
        end
        for (int n = 0; n < 20; n++) begin
            step_in = (n % 2 == 0);
            tick();
        end
        step_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        vec++;
        if (pending_count !== 5'd0 || busy !== 1'b0 || rise_q.size() - r0 != 2) begin
            miscmp++; $display("FAIL flush_ignore got cnt=%0d busy=%b pulses=%0d exp 0 0 2", pending_count, busy, rise_q.size() - r0);
        end
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_pulse();
        logic [1:0] exp;
        dir_in = 1'b1; step_in = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            step_in = 1'b0;
        end
        vec++;
        if ({step_pulse, dir_out, inv_step_pulse} !== 3'b110) begin
            miscmp++; $display("FAIL midrst_pre got %b exp 110", {step_pulse, dir_out, inv_step_pulse});
        end
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({step_pulse, dir_out, busy, pending_count, inv_step_pulse} !== 9'b0_0_0_00000_1) begin
            miscmp++; $display("FAIL midrst_cut got %b exp %b", {step_pulse, dir_out, busy, pending_count, inv_step_pulse}, 9'b000000001);
        end
        dir_in = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        step_in = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            step_in = 1'b0;
            exp = {(n >= 4 && n <= 11), !(n >= 4 && n <= 11)};
            vec++;
            if ({step_pulse, inv_step_pulse} !== exp) begin
                miscmp++; $display("FAIL invert n=%0d got %b exp %b", n, {step_pulse, inv_step_pulse}, exp);
            end
        end
        for (int i = 0; i < 100 && busy; i++) tick();
        vec++;
        if (busy !== 1'b0 || inv_busy !== 1'b0) begin
            miscmp++; $display("FAIL invert_drain got busy=%b inv_busy=%b exp 0 0", busy, inv_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_dir_change();
        test_burst_overflow();
        test_full_with_pop();
        test_enable_flush();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
